// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: time-multiplexes two hex digits onto one shared
// seven-segment decoder. A dark gap of BLANK_CYCLES is inserted between
// slots so the decoder can settle on the next digit before it is lit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress disp1 when d1 == 0).
//
// state  | meaning
// -------+-----------------------------------------------
// SHOW0  | digit 0 lit, numOut = d0 (newest value)
// BLANK0 | both dark, numOut = d1 (pre-settle next digit)
// SHOW1  | digit 1 lit, numOut = d1 (previous value)
// BLANK1 | both dark, numOut = d0
module display_mux_ctrl #(
  parameter int HOLD_CYCLES  = 50,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       num_valid,
  input  logic [3:0] num,
  output logic [3:0] numOut,
  output logic       disp0,
  output logic       disp1,
  output logic       frame_stb
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       d0, d1, d0_nxt, d1_nxt;
  logic             started;
  logic [3:0]       num_out_nxt;
  logic             disp0_nxt, disp1_nxt, frame_stb_nxt;

  // digit shift register: newest value enters d0, old d0 moves to d1
  always_comb begin
    d0_nxt = d0;
    d1_nxt = d1;
    if (num_valid) begin
      d0_nxt = num;
      d1_nxt = d0;
    end
  end

  // slot sequencing; the first edge after reset release opens a fresh SHOW0
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    if (!started) begin
      state_nxt = SHOW0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        SHOW0: if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (BLANK_CYCLES == 0) ? SHOW1 : BLANK0;
        end
        BLANK0: if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW1;
        end
        SHOW1: if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (BLANK_CYCLES == 0) ? SHOW0 : BLANK1;
        end
        BLANK1: if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW0;
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = SHOW0;
        end
      endcase
    end
  end

  // output decode from the upcoming state and digits, so outputs are registered
  always_comb begin
    disp0_nxt     = 1'b0;
    disp1_nxt     = 1'b0;
    num_out_nxt   = d0_nxt;
    frame_stb_nxt = (state_nxt == SHOW0) && (cnt_nxt == '0);
    case (state_nxt)
      SHOW0: begin
        disp0_nxt   = 1'b1;
        num_out_nxt = d0_nxt;
      end
      BLANK0: num_out_nxt = d1_nxt;
      SHOW1: begin
`ifdef LEADING_ZERO_BLANK_EN
        disp1_nxt   = (d1_nxt != 4'h0);
`else
        disp1_nxt   = 1'b1;
`endif
        num_out_nxt = d1_nxt;
      end
      BLANK1: num_out_nxt = d0_nxt;
      default: num_out_nxt = d0_nxt;
    endcase
  end

  // state, counter, digit and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SHOW0;
      cnt       <= '0;
      d0        <= 4'h0;
      d1        <= 4'h0;
      started   <= 1'b0;
      disp0     <= 1'b1;
      disp1     <= 1'b0;
      numOut    <= 4'h0;
      frame_stb <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      d0        <= d0_nxt;
      d1        <= d1_nxt;
      started   <= 1'b1;
      disp0     <= disp0_nxt;
      disp1     <= disp1_nxt;
      numOut    <= num_out_nxt;
      frame_stb <= frame_stb_nxt;
    end
  end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// tb_display_mux_ctrl: random and directed key entry against three
// timing configurations, checked against a frame-position reference model.
module tb_display_mux_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       num_valid;
  logic [3:0] num;

  logic [3:0] a_num_out, b_num_out, c_num_out;
  logic       a_disp0, a_disp1, a_stb;
  logic       b_disp0, b_disp1, b_stb;
  logic       c_disp0, c_disp1, c_stb;

  int n_vec = 0;
  int n_err = 0;

  // reference model: time since release plus the two entered digits
  bit         started;
  int         t;
  logic [3:0] md0, md1;

  always #5 clk = ~clk;

  display_mux_ctrl #(.HOLD_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .num_valid(num_valid), .num(num),
    .numOut(a_num_out), .disp0(a_disp0), .disp1(a_disp1), .frame_stb(a_stb));

  display_mux_ctrl #(.HOLD_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .num_valid(num_valid), .num(num),
    .numOut(b_num_out), .disp0(b_disp0), .disp1(b_disp1), .frame_stb(b_stb));

  display_mux_ctrl #(.HOLD_CYCLES(1), .BLANK_CYCLES(1)) dut_c (
    .clk(clk), .reset(reset), .num_valid(num_valid), .num(num),
    .numOut(c_num_out), .disp0(c_disp0), .disp1(c_disp1), .frame_stb(c_stb));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // frame position -> slot: 0 show0, 1 blank0, 2 show1, 3 blank1
  function automatic int slot_of(input int tt, input int h, input int b);
    int p;
    p = tt % (2 * h + 2 * b);
    if (p < h)              return 0;
    else if (p < h + b)     return 1;
    else if (p < 2 * h + b) return 2;
    else                    return 3;
  endfunction

  task automatic check_dut(input string name, input int h, input int b,
                           input logic d0o, input logic d1o,
                           input logic [3:0] no, input logic stb);
    int         s;
    logic       e_d1;
    logic [3:0] e_num;
    s     = slot_of(t, h, b);
    e_num = (s == 0 || s == 3) ? md0 : md1;
    e_d1  = (s == 2);
`ifdef LEADING_ZERO_BLANK_EN
    if (md1 == 4'h0) e_d1 = 1'b0;
`endif
    chk({name, ".disp0"},  8'(d0o), 8'(s == 0));
    chk({name, ".disp1"},  8'(d1o), 8'(e_d1));
    chk({name, ".numOut"}, 8'(no),  8'(e_num));
    chk({name, ".frame"},  8'(stb), 8'((t % (2 * h + 2 * b)) == 0));
    chk({name, ".excl"},   8'(d0o & d1o), 8'h00);
  endtask

  task automatic check_reset_vals();
    chk("a.rst", {a_disp0, a_disp1, a_stb, 1'b0, a_num_out}, 8'h80);
    chk("b.rst", {b_disp0, b_disp1, b_stb, 1'b0, b_num_out}, 8'h80);
    chk("c.rst", {c_disp0, c_disp1, c_stb, 1'b0, c_num_out}, 8'h80);
  endtask

  // one clock: drive inputs, advance model at posedge, check at negedge
  task automatic step(input logic v, input logic [3:0] n);
    num_valid = v;
    num       = n;
    @(posedge clk);
    if (!started) begin
      started = 1'b1;
      t       = 0;
    end else begin
      t++;
    end
    if (v) begin
      md1 = md0;
      md0 = n;
    end
    @(negedge clk);
    num_valid = 1'b0;
    check_dut("a", 4, 2, a_disp0, a_disp1, a_num_out, a_stb);
    check_dut("b", 4, 0, b_disp0, b_disp1, b_num_out, b_stb);
    check_dut("c", 1, 1, c_disp0, c_disp1, c_num_out, c_stb);
  endtask

  // called at a negedge or mid-cycle; releases reset on a negedge
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    check_reset_vals();
    repeat (cycles) begin
      @(negedge clk);
      check_reset_vals();
    end
    reset   = 1'b1;
    started = 1'b0;
    t       = 0;
    md0     = 4'h0;
    md1     = 4'h0;
  endtask

  initial begin
    reset     = 1'b1;
    num_valid = 1'b0;
    num       = 4'h0;
    started   = 1'b0;
    t         = 0;
    md0       = 4'h0;
    md1       = 4'h0;

    @(negedge clk);
    do_reset(3);

    // idle frames, all digits zero
    repeat (30) step(1'b0, 4'h0);

    // two entries: 5 then A
    step(1'b1, 4'h5);
    step(1'b1, 4'hA);
    repeat (24) step(1'b0, 4'h0);

    // fresh start: single entry leaves d1 = 0, then a second entry
    @(negedge clk);
    do_reset(2);
    step(1'b1, 4'h7);
    repeat (24) step(1'b0, 4'h0);
    step(1'b1, 4'h2);
    repeat (24) step(1'b0, 4'h0);

    // entry during the 2nd cycle of SHOW0 (4/2 config)
    for (int k = 0; k < 24 && (t % 12) != 1; k++) step(1'b0, 4'h0);
    step(1'b1, 4'h3);
    repeat (6) step(1'b0, 4'h0);

    // random entries, including back-to-back strobes
    repeat (600) step($urandom_range(0, 2) == 0, 4'($urandom));

    // reset asserted in the 3rd cycle of SHOW1 (4/2 config)
    for (int k = 0; k < 24 && (t % 12) != 8; k++) step(1'b0, 4'h0);
    #2;
    do_reset(2);
    repeat (16) step($urandom_range(0, 1) == 0, 4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_mux_ctrl.md
DISPLAY_MUX_CTRL -- requirements
Module: display_mux_ctrl

Interface
REQ-001 The block SHALL have a parameter HOLD_CYCLES, default 50: clk cycles each digit is lit per slot; legal range 1 or more.
REQ-002 The block SHALL have a parameter BLANK_CYCLES, default 2: clk cycles both digits are dark between slots; legal range 0 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port num_valid, input, 1 bit: single-cycle strobe indicating that num carries a new key value.
REQ-006 The block SHALL have port num, input, 4 bits: new hex digit value, sampled only when num_valid is 1.
REQ-007 The block SHALL have port numOut, output, 4 bits: digit value presented to the shared seven-segment decoder.
REQ-008 The block SHALL have port disp0, output, 1 bit: active-high enable of digit 0 (newest value).
REQ-009 The block SHALL have port disp1, output, 1 bit: active-high enable of digit 1 (previous value).
REQ-010 The block SHALL have port frame_stb, output, 1 bit: one-cycle pulse marking the start of each display frame.

Function
REQ-011 The block SHALL hold two 4-bit digit registers, d0 and d1; when num_valid is 1 at a posedge, d0 SHALL take num and d1 SHALL take the old d0, both in the same edge.
REQ-012 When num_valid is 0, d0 and d1 SHALL hold their values.
REQ-013 The block SHALL implement a four-state FSM cycling SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
REQ-014 A cycle counter SHALL clear on every state change; SHOWx SHALL last exactly HOLD_CYCLES cycles and BLANKx exactly BLANK_CYCLES cycles.
REQ-015 When BLANK_CYCLES is 0, the BLANK states SHALL be skipped (SHOW0 -> SHOW1 -> SHOW0) with no dark cycle.
REQ-016 Counter width SHALL be sized for the larger of HOLD_CYCLES and BLANK_CYCLES, with no wrap before the terminal count.
REQ-017 Outputs SHALL be Moore, decoded from state and registers with no combinational path from num or num_valid.
REQ-018 In SHOW0, disp0 SHALL be 1, disp1 SHALL be 0, and numOut SHALL equal d0.
REQ-019 In SHOW1, disp0 SHALL be 0, disp1 SHALL be 1, and numOut SHALL equal d1.
REQ-020 In BLANK0, both enables SHALL be 0 and numOut SHALL equal d1, so the decoder pre-settles on the next digit.
REQ-021 In BLANK1, both enables SHALL be 0 and numOut SHALL equal d0.
REQ-022 disp0 and disp1 SHALL never be 1 in the same cycle.
REQ-023 frame_stb SHALL be 1 only during the first cycle of SHOW0 and SHALL be 0 during reset.
REQ-024 A num_valid pulse SHALL NOT alter FSM state or the counter; the new value SHALL appear on numOut from the next cycle if the current slot shows the affected digit.
REQ-025 Back-to-back num_valid pulses SHALL each shift the digits, with none dropped.

Reset
REQ-026 While reset is 0, the state SHALL be SHOW0, the counter 0, d0 = d1 = 0, disp0 = 1, disp1 = 0, numOut = 0, and frame_stb = 0.
REQ-027 Reset asserted mid-slot SHALL abort immediately; after release, the first posedge SHALL begin a full SHOW0 slot, with frame_stb = 1 in that first cycle.

Configuration
REQ-028 When the macro LEADING_ZERO_BLANK_EN is defined, disp1 SHALL be forced to 0 in SHOW1 whenever d1 equals 0; slot timing and all other outputs SHALL be unchanged.
REQ-029 When LEADING_ZERO_BLANK_EN is undefined, d1 equal to 0 SHALL be displayed normally.

Verification (HOLD_CYCLES=4, BLANK_CYCLES=2 unless stated)
REQ-030 Release reset, no input -> repeating 12-cycle frame (disp0 1 for 4, dark 2, disp1 1 for 4, dark 2), with frame_stb every 12 cycles and numOut = 0 throughout.
REQ-031 num_valid with num=0x5 then num_valid with num=0xA -> d0=0xA, d1=0x5; numOut = 0xA in SHOW0 and BLANK1, and 0x5 in SHOW1 and BLANK0.
REQ-032 num_valid with num=0x3 in the 2nd cycle of SHOW0 -> numOut = 0x3 from the 3rd cycle, and SHOW0 still ends after the 4th cycle.
REQ-033 BLANK_CYCLES=0 -> an 8-cycle frame with exactly one of disp0 or disp1 high every cycle.
REQ-034 Reset pulsed in the 3rd cycle of SHOW1 -> all outputs return to reset values; after release, a full 4-cycle SHOW0 with frame_stb in its first cycle.
REQ-035 With LEADING_ZERO_BLANK_EN defined and one entry of 0x7 (d1=0) -> disp1 stays 0 in every SHOW1; after a second entry of 0x2, disp1 shows d1=0x7.
